// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// HI/LO multiply/divide unit for a MIPS-style EX stage.
//   - MULT / MULTU write the 64-bit product into {HI,LO} in a single cycle.
//   - MTHI / MTLO load HI / LO from operand_1; MFHI / MFLO read them back
//     on 'result' combinationally.
//   - DIV / DIVU (only when MULDIV_DIV_EN is defined) run a 32-step
//     restoring divider. The pipeline is held through the issue cycle and
//     the 32 BUSY cycles. The DONE cycle then writes HI=remainder and
//     LO=quotient.
//
// Configuration macro: MULDIV_DIV_EN. When it is undefined, the divider is
// not built. DIV/DIVU then behave like any unrecognised funct, and
// stall_req is tied low.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-low reset
//   en         in   1   valid instruction in EX this cycle
//   flush      in   1   pipeline flush; aborts a divide, blocks HI/LO writes
//   funct      in   6   ALU function code
//   operand_1  in  32   rs: dividend / multiplicand / MTHI, MTLO source
//   operand_2  in  32   rt: divisor / multiplier
//   result     out 32   HI (MFHI) or LO (MFLO), otherwise 0
//   stall_req  out  1   hold the pipeline while a divide is in progress
//   hi, lo     out 32   current HI / LO register values
// ---------------------------------------------------------------------------
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        flush,
   input  logic [5:0]  funct,
   input  logic [31:0] operand_1,
   input  logic [31:0] operand_2,
   output logic [31:0] result,
   output logic        stall_req,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] FUNCT_MFHI  = 6'h10;
   localparam logic [5:0] FUNCT_MTHI  = 6'h11;
   localparam logic [5:0] FUNCT_MFLO  = 6'h12;
   localparam logic [5:0] FUNCT_MTLO  = 6'h13;
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;

   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic signed [63:0] prod_s;
   logic [63:0]        prod_u;
   logic               accept;

   assign prod_s = 64'($signed(operand_1)) * 64'($signed(operand_2));
   assign prod_u = {32'd0, operand_1} * {32'd0, operand_2};

`ifdef MULDIV_DIV_EN
   localparam logic [5:0] FUNCT_DIV  = 6'h1A;
   localparam logic [5:0] FUNCT_DIVU = 6'h1B;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

   div_state_t  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [32:0] rem_shift;
   logic [33:0] diff;
   logic        is_div, is_signed;
   logic        div_done;
   logic [31:0] quo_final, rem_final;

   assign is_div    = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
   assign is_signed = (funct == FUNCT_DIV);

   // Single-cycle ops are taken only while the divider is idle. A busy
   // divider owns HI/LO until it finishes or is flushed.
   assign accept    = en && !flush && (state_q == IDLE);
   assign stall_req = !flush && (((state_q == IDLE) && en && is_div) || (state_q == BUSY));
   assign div_done  = (state_q == DONE) && !flush;

   // A restoring step shifts the next dividend bit into the partial
   // remainder. It subtracts the divisor when the borrow bit stays clear.
   // The quotient bits shift into the dividend register as it empties.
   assign rem_shift = {rem_q, dvd_q[31]};
   assign diff      = {1'b0, rem_shift} - {2'b00, dvs_q};

   // A zero divisor gives all-ones naturally from the unsigned core. Force it
   // anyway so the signed fixup cannot disturb it. The remainder then holds
   // |dividend|, and the dividend-sign fixup returns the raw operand_1.
   assign quo_final = (dvs_q == 32'd0) ? 32'hFFFF_FFFF : (neg_quo_q ? -dvd_q : dvd_q);
   assign rem_final = neg_rem_q ? -rem_q : rem_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      rem_d     = rem_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (en && is_div) begin
                  dvd_d     = (is_signed && operand_1[31]) ? -operand_1 : operand_1;
                  dvs_d     = (is_signed && operand_2[31]) ? -operand_2 : operand_2;
                  rem_d     = '0;
                  cnt_d     = '0;
                  neg_quo_d = is_signed && (operand_1[31] ^ operand_2[31]);
                  neg_rem_d = is_signed && operand_1[31];
                  state_d   = BUSY;
               end
            end
            BUSY: begin
               if (!diff[33]) begin
                  rem_d = diff[31:0];
                  dvd_d = {dvd_q[30:0], 1'b1};
               end else begin
                  rem_d = rem_shift[31:0];
                  dvd_d = {dvd_q[30:0], 1'b0};
               end
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'd31) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end
`else
   assign accept    = en && !flush;
   assign stall_req = 1'b0;
`endif

   // HI/LO next-state. Single-cycle ops write only when accepted. A finishing
   // divide writes its result at the edge that ends the DONE cycle.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (accept) begin
         case (funct)
            FUNCT_MULT:  {hi_d, lo_d} = prod_s;
            FUNCT_MULTU: {hi_d, lo_d} = prod_u;
            FUNCT_MTHI:  hi_d = operand_1;
            FUNCT_MTLO:  lo_d = operand_1;
            default: begin
               hi_d = hi_q;
               lo_d = lo_q;
            end
         endcase
      end
`ifdef MULDIV_DIV_EN
      if (div_done) begin
         hi_d = rem_final;
         lo_d = quo_final;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   always_comb begin
      result = 32'd0;
      if (funct == FUNCT_MFHI) begin
         result = hi_q;
      end else if (funct == FUNCT_MFLO) begin
         result = lo_q;
      end
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: en  input  1  valid instruction present in EX stage this cycle.
REQ-004 SHALL have port: flush  input  1  pipeline flush; aborts an in-flight divide.
REQ-005 SHALL have port: funct  input  6  ALU function code from ID stage, using the `FUNCT_*` encodings in funct.v.
REQ-006 SHALL have port: operand_1  input  32  rs value (dividend / multiplicand / MTHI, MTLO source).
REQ-007 SHALL have port: operand_2  input  32  rt value (divisor / multiplier).
REQ-008 SHALL have port: result  output  32  MFHI/MFLO read data, 0 for all other functs.
REQ-009 SHALL have port: stall_req  output  1  hold the pipeline while a divide is in progress.
REQ-010 SHALL have ports: hi, lo  output  32 each  current HI/LO register values.

Function
REQ-011 SHALL act only when en=1; with en=0, HI/LO hold and no operation starts.
REQ-012 MULT (0x18) / MULTU (0x19) SHALL write the signed / unsigned 64-bit product {HI,LO} at the next edge, stall_req=0, single-cycle.
REQ-013 MTHI (0x11) / MTLO (0x13) SHALL write operand_1 to HI / LO at the next edge.
REQ-014 MFHI (0x10) / MFLO (0x12) SHALL drive result combinationally with the current HI / LO.
REQ-015 Divider FSM SHALL have states IDLE, BUSY, DONE.
REQ-016 IDLE: en=1 and funct=DIV (0x1A) or DIVU (0x1B) SHALL latch |operands| (DIV) or raw operands (DIVU), clear the 6-bit counter, and go to BUSY; stall_req=1 combinationally in this issue cycle.
REQ-017 BUSY: one restoring quotient bit per cycle; counter increments 0..31; at counter=31 go to DONE; stall_req=1 throughout.
REQ-018 DONE: HI=remainder, LO=quotient written at this edge; stall_req=0; go to IDLE; a DIV/DIVU still on the inputs SHALL NOT restart.
REQ-019 Divide latency SHALL be 34 cycles from issue to HI/LO valid: 1 issue, 32 BUSY, 1 DONE.
REQ-020 Signed fixup: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-021 Divisor=0 SHALL still take the full latency and give LO=0xFFFFFFFF, HI=dividend (raw operand_1).
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 flush=1 in any state SHALL force IDLE at the next edge with HI/LO unchanged and stall_req=0 in that cycle; flush overrides a new issue.
REQ-024 Funct codes other than those above SHALL leave HI/LO and the FSM unaffected, with result=0.

Reset
REQ-025 rst=0 at an edge SHALL set HI=0, LO=0, FSM=IDLE, counter=0 and internal dividend/divisor/partial-remainder registers to 0, overriding flush and en.
REQ-026 Outputs after reset: result=0 (except MFHI/MFLO reading 0), stall_req=0, hi=0, lo=0.
REQ-027 Reset asserted during BUSY SHALL abort the divide with no HI/LO write.

Configuration
REQ-028 Macro MULDIV_DIV_EN SHALL compile the divider in or out.
REQ-029 With MULDIV_DIV_EN defined: DIV/DIVU behave per REQ-015..REQ-023.
REQ-030 Without it: no FSM or counter; DIV/DIVU behave as unrecognised functs (REQ-024); stall_req is constant 0; MULT/MULTU and MFHI/MTHI/MFLO/MTLO are unchanged.

Verification
REQ-031 MULT 0xFFFFFFFE x 0x00000003 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA, stall_req never asserted.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 DIV -7 (0xFFFFFFF9) / 2, inputs held during the stall -> stall_req high 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; the next cycle is IDLE with no restart.
REQ-034 DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100 after 34 cycles.
REQ-035 Issue DIVU 50/7, flush on cycle 10 -> IDLE next edge, stall_req=0, HI/LO keep prior values; a following MFLO returns the old LO.
REQ-036 MTHI 0x1234 then MFHI on the next cycle -> result=0x00001234; rst=0 mid-divide -> HI=LO=0, stall_req=0 next cycle.
